decoder_stage: RTL and testbench
================================

DECODER_STAGE -- requirements
Module: decoder_stage

Interface
- REQ-001 Parameters (name, default, meaning): DWIDTH 32, data width; AWIDTH 5, register address width; PC_WIDTH 32, PC width; IWIDTH 32, instruction width.
- REQ-002 Ports (name, direction, width, meaning):
  - ds_clk, in, 1, single clock.
  - ds_rst, in, 1, reset; asynchronous, active-high.
  - ds_i_instr, in, IWIDTH, instruction.
  - ds_i_pc, in, PC_WIDTH, instruction PC.
  - ds_i_ce, in, 1, input valid.
  - ds_i_stall, in, 1, downstream stall.
  - ds_i_flush, in, 1, flush.
  - ds_we, in, 1, register-file write enable.
  - ds_data_in_rd, in, DWIDTH, write data.
  - ds_o_pc, out, PC_WIDTH, registered PC.
  - ds_o_addr_rs1_p, out, AWIDTH, rs1 index.
  - ds_o_addr_rs2_p, out, AWIDTH, rs2 index.
  - ds_o_addr_rd_p, out, AWIDTH, rd index.
  - ds_o_funct3, out, 3, funct3.
  - ds_o_imm, out, DWIDTH, sign-extended immediate.
  - ds_o_alu, out, ALU_WIDTH, one-hot ALU operation.
  - ds_o_opcode, out, OPCODE_WIDTH, one-hot instruction class.
  - ds_o_exception, out, EXCEPTION_WIDTH, exception flags.
  - ds_o_ce, out, 1, output valid.
  - ds_o_stall, out, 1, stall out.
  - ds_o_flush, out, 1, flush out.
  - ds_data_out_rs1, out, DWIDTH, rs1 data.
  - ds_data_out_rs2, out, DWIDTH, rs2 data.

Function
- REQ-003 Decode: RV32I base ISA; all decoded outputs are registered with 1-cycle latency and update on the ds_clk rising edge when ds_i_ce=1 and ds_i_stall=0.
- REQ-004 Field mapping: rd=instr[11:7], rs1=instr[19:15], rs2=instr[24:20], funct3=instr[14:12]; ds_o_pc captures ds_i_pc.
- REQ-005 Immediates:
  - I-type: instr[31:20], sign-extended; applies to OP-IMM, LOAD, JALR and SYSTEM.
  - S-type: {31:25, 11:7}.
  - B-type: {31, 7, 30:25, 11:8, 0}.
  - U-type: {31:12, 12'b0}.
  - J-type: {31, 19:12, 20, 30:21, 0}.
  - R-type: imm=0.
- REQ-006 ds_o_opcode is one-hot, 11 bits, in order bit0..10: RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE.
- REQ-007 ds_o_alu is one-hot, 14 bits, in order bit0..13: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, EQ, NEQ, GE, GEU.
  - funct7[5] selects SUB/SRA.
  - Branches map BEQ→EQ, BNE→NEQ, BLT→SLT, BGE→GE, BLTU→SLTU, BGEU→GEU.
  - LOAD, STORE, JAL, JALR, LUI, AUIPC decode to ADD.
- REQ-008 ds_o_exception is 4 bits: bit0 ILLEGAL, bit1 ECALL (0x00000073), bit2 EBREAK (0x00100073), bit3 MRET (0x30200073).
  - ILLEGAL is set for an unknown opcode, instr[1:0]≠2'b11, or an invalid funct3/funct7 combination.
  - On ILLEGAL, ds_o_opcode=0 and ds_o_alu=0.
- REQ-009 Register file: 32×DWIDTH.
  - Synchronous write at the rising edge when ds_we=1; write address is ds_i_instr[11:7].
  - Writes to x0 are ignored; x0 always reads 0.
- REQ-010 Read ports: ds_data_out_rs1/rs2 are registered reads of the rs1/rs2 fields of ds_i_instr, on the same enable as REQ-003.
  - A same-cycle write to the read address returns the new data (write-first bypass).
- REQ-011 ds_o_ce: on each edge, ds_o_ce ← ds_i_ce, except:
  - it holds when ds_i_stall=1;
  - it is 0 when ds_i_flush=1, and flush overrides stall.
- REQ-012 Passthroughs: ds_o_stall=ds_i_stall and ds_o_flush=ds_i_flush, both combinational.
- REQ-013 When ds_i_ce=0 or ds_i_stall=1, all decoded outputs hold their previous values.

Reset
- REQ-014 While ds_rst=1, all registered outputs clear to 0 asynchronously, and every register-file entry clears to 0.
- REQ-015 A reset asserted mid-operation discards the in-flight decode; the first decode occurs at the first enabled edge after deassertion.

Structure
- REQ-016 A shared package/header holds:
  - ALU_WIDTH=14, OPCODE_WIDTH=11, EXCEPTION_WIDTH=4;
  - the bit-index constants for REQ-006 to REQ-008;
  - the RV32I opcode constants.
- REQ-017 The block has one sub-module, decoder_regfile (2 read ports, 1 write port), instantiated in decoder_stage; decode logic is inline.

Verification
- REQ-018 addi x1,x0,5 (0x00500093), ce=1 → next edge: rd=1, rs1=0, imm=0x00000005, opcode=ITYPE, alu=ADD, ex=0, o_ce=1.
- REQ-019 sub x2,x1,x2 (0x40208133) → rd=2, rs1=1, rs2=2, opcode=RTYPE, alu=SUB, imm=0.
- REQ-020 beq x1,x2,-4 (0xFE208EE3) → imm=0xFFFFFFFC, opcode=BRANCH, alu=EQ, funct3=000.
- REQ-021 lui x5,0x12345 (0x123452B7) → imm=0x12345000, opcode=LUI, rd=5.
- REQ-022 0xFFFFFFFF → ex bit0=1, opcode=0, alu=0; 0x00000073 → ex bit1=1.
- REQ-023 Register-file and control checks:
  - instr with rd=3, we=1, data=0xDEADBEEF, then an instr with rs1=3 → rs1 data 0xDEADBEEF.
  - Writing x0 → rs1 data from x0 reads 0.
  - flush=1 → o_ce=0 at the next edge.
  - stall=1 → outputs held.

Source files
------------

// File: rtl/decoder_stage_pkg.sv
// decoder_stage_pkg: shared widths, one-hot bit positions and RV32I opcodes for the decode stage.
package decoder_stage_pkg;
   localparam int ALU_WIDTH       = 14;
   localparam int OPCODE_WIDTH    = 11;
   localparam int EXCEPTION_WIDTH = 4;
   localparam int OPC_RTYPE = 0, OPC_ITYPE = 1, OPC_LOAD = 2, OPC_STORE = 3, OPC_BRANCH = 4, OPC_JAL = 5;
   localparam int OPC_JALR = 6, OPC_LUI = 7, OPC_AUIPC = 8, OPC_SYSTEM = 9, OPC_FENCE = 10;
   localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLT = 2, ALU_SLTU = 3, ALU_XOR = 4, ALU_OR = 5, ALU_AND = 6;
   localparam int ALU_SLL = 7, ALU_SRL = 8, ALU_SRA = 9, ALU_EQ = 10, ALU_NEQ = 11, ALU_GE = 12, ALU_GEU = 13;
   localparam int EX_ILLEGAL = 0, EX_ECALL = 1, EX_EBREAK = 2, EX_MRET = 3;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

   function automatic logic [ALU_WIDTH-1:0] alu_oh(input int idx);
      return ALU_WIDTH'(1) << idx;
   endfunction

   function automatic logic [OPCODE_WIDTH-1:0] opc_oh(input int idx);
      return OPCODE_WIDTH'(1) << idx;
   endfunction

   // shared by OP and OP-IMM; alt is funct7[5] where it selects SUB/SRA
   function automatic logic [ALU_WIDTH-1:0] alu_arith(input logic [2:0] f3, input logic alt);
      return alu_oh(f3 == 3'b000 ? (alt ? ALU_SUB : ALU_ADD) :
                    f3 == 3'b001 ? ALU_SLL :
                    f3 == 3'b010 ? ALU_SLT :
                    f3 == 3'b011 ? ALU_SLTU :
                    f3 == 3'b100 ? ALU_XOR :
                    f3 == 3'b101 ? (alt ? ALU_SRA : ALU_SRL) :
                    f3 == 3'b110 ? ALU_OR : ALU_AND);
   endfunction
endpackage

// File: rtl/decoder_regfile.sv
// decoder_regfile: 2R1W register file with registered, write-first reads; x0 is hardwired to zero.
module decoder_regfile #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [AWIDTH-1:0] waddr_i,
   input  logic [DWIDTH-1:0] wdata_i,
   input  logic [AWIDTH-1:0] raddr1_i,
   input  logic [AWIDTH-1:0] raddr2_i,
   output logic [DWIDTH-1:0] rdata1_o,
   output logic [DWIDTH-1:0] rdata2_o
);
   localparam int DEPTH = 1 << AWIDTH;
   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DWIDTH-1:0] rd1_q, rd2_q, rd1_d, rd2_d;
   logic              wr;
   assign wr = we_i && waddr_i != '0;
   assign rd1_d = (wr && waddr_i == raddr1_i) ? wdata_i : mem_q[raddr1_i];
   assign rd2_d = (wr && waddr_i == raddr2_i) ? wdata_i : mem_q[raddr2_i];
   assign rdata1_o = rd1_q;
   assign rdata2_o = rd2_q;
   // entry 0 is never written, so it reads zero without a special case
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd1_q <= '0;
         rd2_q <= '0;
      end else begin
         if (wr) mem_q[waddr_i] <= wdata_i;
         if (en_i) begin
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
         end
      end
endmodule

// File: rtl/decoder_stage.sv
// decoder_stage: registered RV32I decode with one-hot class/ALU outputs, exception flags and register-file reads.
module decoder_stage
   import decoder_stage_pkg::*;
#(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 5,
   parameter int PC_WIDTH = 32,
   parameter int IWIDTH   = 32
) (
   input  logic                       ds_clk,
   input  logic                       ds_rst,
   input  logic [IWIDTH-1:0]          ds_i_instr,
   input  logic [PC_WIDTH-1:0]        ds_i_pc,
   input  logic                       ds_i_ce,
   input  logic                       ds_i_stall,
   input  logic                       ds_i_flush,
   input  logic                       ds_we,
   input  logic [DWIDTH-1:0]          ds_data_in_rd,
   output logic [PC_WIDTH-1:0]        ds_o_pc,
   output logic [AWIDTH-1:0]          ds_o_addr_rs1_p,
   output logic [AWIDTH-1:0]          ds_o_addr_rs2_p,
   output logic [AWIDTH-1:0]          ds_o_addr_rd_p,
   output logic [2:0]                 ds_o_funct3,
   output logic [DWIDTH-1:0]          ds_o_imm,
   output logic [ALU_WIDTH-1:0]       ds_o_alu,
   output logic [OPCODE_WIDTH-1:0]    ds_o_opcode,
   output logic [EXCEPTION_WIDTH-1:0] ds_o_exception,
   output logic                       ds_o_ce,
   output logic                       ds_o_stall,
   output logic                       ds_o_flush,
   output logic [DWIDTH-1:0]          ds_data_out_rs1,
   output logic [DWIDTH-1:0]          ds_data_out_rs2
);
   logic [6:0]                 op, f7;
   logic [2:0]                 f3;
   logic [31:0]                ins;
   logic [DWIDTH-1:0]          imm_i, imm_s, imm_b, imm_u, imm_j, imm_d, imm_q;
   logic [ALU_WIDTH-1:0]       alu_d, alu_q;
   logic [OPCODE_WIDTH-1:0]    opc_d, opc_q;
   logic [EXCEPTION_WIDTH-1:0] exc_d, exc_q;
   logic [PC_WIDTH-1:0]        pc_q;
   logic [AWIDTH-1:0]          rs1_q, rs2_q, rd_q;
   logic [2:0]                 f3_q;
   logic                       ce_d, ce_q, en, ill, is_ecall, is_ebreak, is_mret;
   assign ins = ds_i_instr[31:0];
   assign op = ins[6:0];
   assign f3 = ins[14:12];
   assign f7 = ins[31:25];
   assign imm_i = DWIDTH'($signed(ins[31:20]));
   assign imm_s = DWIDTH'($signed({ins[31:25], ins[11:7]}));
   assign imm_b = DWIDTH'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
   assign imm_u = DWIDTH'($signed({ins[31:12], 12'b0}));
   assign imm_j = DWIDTH'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
   assign is_ecall = ins == INSTR_ECALL;
   assign is_ebreak = ins == INSTR_EBREAK;
   assign is_mret = ins == INSTR_MRET;
   assign en = ds_i_ce && !ds_i_stall;
   assign ce_d = ds_i_flush ? 1'b0 : ds_i_stall ? ce_q : ds_i_ce;
   always_comb begin
      opc_d = '0;
      alu_d = alu_oh(ALU_ADD);
      imm_d = '0;
      ill = 1'b0;
      case (op)
         OP_RTYPE: begin
            opc_d = opc_oh(OPC_RTYPE);
            alu_d = alu_arith(f3, f7[5]);
            ill = f7 != 7'h00 && !(f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
         end
         OP_ITYPE: begin
            opc_d = opc_oh(OPC_ITYPE);
            imm_d = imm_i;
            alu_d = alu_arith(f3, f3 == 3'b101 && f7[5]);
            ill = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
         end
         OP_LOAD: begin
            opc_d = opc_oh(OPC_LOAD);
            imm_d = imm_i;
            ill = f3 == 3'b011 || f3[2:1] == 2'b11;
         end
         OP_STORE: begin
            opc_d = opc_oh(OPC_STORE);
            imm_d = imm_s;
            ill = f3[2] || f3[1:0] == 2'b11;
         end
         OP_BRANCH: begin
            opc_d = opc_oh(OPC_BRANCH);
            imm_d = imm_b;
            alu_d = alu_oh(f3 == 3'b000 ? ALU_EQ : f3 == 3'b001 ? ALU_NEQ : f3 == 3'b100 ? ALU_SLT :
                           f3 == 3'b101 ? ALU_GE : f3 == 3'b110 ? ALU_SLTU : ALU_GEU);
            ill = f3[2:1] == 2'b01;
         end
         OP_JAL: begin
            opc_d = opc_oh(OPC_JAL);
            imm_d = imm_j;
         end
         OP_JALR: begin
            opc_d = opc_oh(OPC_JALR);
            imm_d = imm_i;
            ill = f3 != 3'b000;
         end
         OP_LUI: begin
            opc_d = opc_oh(OPC_LUI);
            imm_d = imm_u;
         end
         OP_AUIPC: begin
            opc_d = opc_oh(OPC_AUIPC);
            imm_d = imm_u;
         end
         // funct3=000 is only legal for the exact ECALL/EBREAK/MRET encodings; others are CSR ops
         OP_SYSTEM: begin
            opc_d = opc_oh(OPC_SYSTEM);
            imm_d = imm_i;
            alu_d = '0;
            ill = f3 == 3'b100 || (f3 == 3'b000 && !(is_ecall || is_ebreak || is_mret));
         end
         OP_FENCE: begin
            opc_d = opc_oh(OPC_FENCE);
            alu_d = '0;
            ill = f3[2:1] != 2'b00;
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         opc_d = '0;
         alu_d = '0;
      end
      exc_d = '0;
      exc_d[EX_ILLEGAL] = ill;
      exc_d[EX_ECALL] = is_ecall;
      exc_d[EX_EBREAK] = is_ebreak;
      exc_d[EX_MRET] = is_mret;
   end
   always_ff @(posedge ds_clk or posedge ds_rst)
      if (ds_rst) begin
         pc_q <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
         rd_q <= '0;
         f3_q <= '0;
         imm_q <= '0;
         alu_q <= '0;
         opc_q <= '0;
         exc_q <= '0;
         ce_q <= 1'b0;
      end else begin
         ce_q <= ce_d;
         if (en) begin
            pc_q <= ds_i_pc;
            rs1_q <= AWIDTH'(ins[19:15]);
            rs2_q <= AWIDTH'(ins[24:20]);
            rd_q <= AWIDTH'(ins[11:7]);
            f3_q <= f3;
            imm_q <= imm_d;
            alu_q <= alu_d;
            opc_q <= opc_d;
            exc_q <= exc_d;
         end
      end
   decoder_regfile #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_rf (
      .clk_i   (ds_clk),
      .rst_i   (ds_rst),
      .en_i    (en),
      .we_i    (ds_we),
      .waddr_i (AWIDTH'(ins[11:7])),
      .wdata_i (ds_data_in_rd),
      .raddr1_i(AWIDTH'(ins[19:15])),
      .raddr2_i(AWIDTH'(ins[24:20])),
      .rdata1_o(ds_data_out_rs1),
      .rdata2_o(ds_data_out_rs2)
   );
   assign ds_o_pc = pc_q;
   assign ds_o_addr_rs1_p = rs1_q;
   assign ds_o_addr_rs2_p = rs2_q;
   assign ds_o_addr_rd_p = rd_q;
   assign ds_o_funct3 = f3_q;
   assign ds_o_imm = imm_q;
   assign ds_o_alu = alu_q;
   assign ds_o_opcode = opc_q;
   assign ds_o_exception = exc_q;
   assign ds_o_ce = ce_q;
   assign ds_o_stall = ds_i_stall;
   assign ds_o_flush = ds_i_flush;
endmodule

// File: tb/tb_decoder_stage.sv
// tb_decoder_stage: scoreboard bench for decoder_stage; expectations come from hand-decoded vectors and a register model.
module tb_decoder_stage;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] ds_i_instr = '0, ds_i_pc = '0, ds_data_in_rd = '0;
   logic        ds_i_ce = 1'b0, ds_i_stall = 1'b0, ds_i_flush = 1'b0, ds_we = 1'b0;
   logic [31:0] ds_o_pc, ds_o_imm, ds_data_out_rs1, ds_data_out_rs2;
   logic [4:0]  ds_o_addr_rs1_p, ds_o_addr_rs2_p, ds_o_addr_rd_p;
   logic [2:0]  ds_o_funct3;
   logic [13:0] ds_o_alu;
   logic [10:0] ds_o_opcode;
   logic [3:0]  ds_o_exception;
   logic        ds_o_ce, ds_o_stall, ds_o_flush;

   always #5 clk = ~clk;

   decoder_stage dut (
      .ds_clk(clk), .ds_rst(rst), .ds_i_instr(ds_i_instr), .ds_i_pc(ds_i_pc), .ds_i_ce(ds_i_ce),
      .ds_i_stall(ds_i_stall), .ds_i_flush(ds_i_flush), .ds_we(ds_we), .ds_data_in_rd(ds_data_in_rd),
      .ds_o_pc(ds_o_pc), .ds_o_addr_rs1_p(ds_o_addr_rs1_p), .ds_o_addr_rs2_p(ds_o_addr_rs2_p),
      .ds_o_addr_rd_p(ds_o_addr_rd_p), .ds_o_funct3(ds_o_funct3), .ds_o_imm(ds_o_imm), .ds_o_alu(ds_o_alu),
      .ds_o_opcode(ds_o_opcode), .ds_o_exception(ds_o_exception), .ds_o_ce(ds_o_ce), .ds_o_stall(ds_o_stall),
      .ds_o_flush(ds_o_flush), .ds_data_out_rs1(ds_data_out_rs1), .ds_data_out_rs2(ds_data_out_rs2)
   );

   typedef struct {
      string tag; logic [31:0] instr, imm; logic [10:0] opc; logic [13:0] alu; logic [3:0] ex; logic imm_c, alu_c;
   } vec_t;
   typedef struct {
      string tag; logic [31:0] pc, imm, d1, d2; logic [4:0] rd, rs1, rs2; logic [2:0] f3;
      logic [13:0] alu; logic [10:0] opc; logic [3:0] ex; logic ce, imm_c, alu_c;
   } exp_t;

   exp_t        sb[$];
   exp_t        last;
   logic [31:0] regs [32];
   logic [31:0] pc_n = 32'h1000;
   int          n_chk = 0, n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   function automatic vec_t v(input string tag, input logic [31:0] instr, input logic [31:0] imm, input logic [10:0] opc,
                              input logic [13:0] alu, input logic [3:0] ex, input logic imm_c = 1'b1, input logic alu_c = 1'b1);
      vec_t r;
      r.tag = tag; r.instr = instr; r.imm = imm; r.opc = opc; r.alu = alu; r.ex = ex; r.imm_c = imm_c; r.alu_c = alu_c;
      return r;
   endfunction

   function automatic exp_t zero_exp(input string tag);
      exp_t e;
      e.tag = tag; e.pc = '0; e.imm = '0; e.d1 = '0; e.d2 = '0; e.rd = '0; e.rs1 = '0; e.rs2 = '0; e.f3 = '0;
      e.alu = '0; e.opc = '0; e.ex = '0; e.ce = 1'b0; e.imm_c = 1'b1; e.alu_c = 1'b1;
      return e;
   endfunction

   task automatic compare_out(input exp_t e);
      check({e.tag, ".pc"}, ds_o_pc, e.pc);
      check({e.tag, ".rd"}, 32'(ds_o_addr_rd_p), 32'(e.rd));
      check({e.tag, ".rs1"}, 32'(ds_o_addr_rs1_p), 32'(e.rs1));
      check({e.tag, ".rs2"}, 32'(ds_o_addr_rs2_p), 32'(e.rs2));
      check({e.tag, ".f3"}, 32'(ds_o_funct3), 32'(e.f3));
      if (e.imm_c) check({e.tag, ".imm"}, ds_o_imm, e.imm);
      if (e.alu_c) check({e.tag, ".alu"}, 32'(ds_o_alu), 32'(e.alu));
      check({e.tag, ".opc"}, 32'(ds_o_opcode), 32'(e.opc));
      check({e.tag, ".ex"}, 32'(ds_o_exception), 32'(e.ex));
      check({e.tag, ".ce"}, 32'(ds_o_ce), 32'(e.ce));
      check({e.tag, ".rs1_data"}, ds_data_out_rs1, e.d1);
      check({e.tag, ".rs2_data"}, ds_data_out_rs2, e.d2);
   endtask

   task automatic drive(input vec_t x, input logic ce, input logic stall, input logic flush, input logic we, input logic [31:0] wd);
      exp_t        e;
      logic [31:0] ins;
      logic [4:0]  rd, rs1, rs2;
      ins = x.instr; rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
      ds_i_instr = ins; ds_i_pc = pc_n; ds_i_ce = ce; ds_i_stall = stall; ds_i_flush = flush; ds_we = we; ds_data_in_rd = wd;
      e = last;
      e.tag = x.tag;
      e.ce = flush ? 1'b0 : stall ? last.ce : ce;
      if (ce && !stall) begin
         e.pc = pc_n; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = ins[14:12];
         e.imm = x.imm; e.opc = x.opc; e.alu = x.alu; e.ex = x.ex; e.imm_c = x.imm_c; e.alu_c = x.alu_c;
         e.d1 = (we && rd != 0 && rd == rs1) ? wd : regs[rs1];
         e.d2 = (we && rd != 0 && rd == rs2) ? wd : regs[rs2];
      end
      if (we && rd != 0) regs[rd] = wd;
      pc_n += 4;
      sb.push_back(e);
      last = e;
      #1;
      check({x.tag, ".stall_o"}, 32'(ds_o_stall), 32'(stall));
      check({x.tag, ".flush_o"}, 32'(ds_o_flush), 32'(flush));
      @(posedge clk);
      #1;
      if (sb.size() == 0) check({x.tag, ".sb_empty"}, 32'd0, 32'd1);
      else compare_out(sb.pop_front());
   endtask

   vec_t tbl[$];
   vec_t addi_v, sub_v;

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = '0;
      last = zero_exp("reset");
      tbl = '{
         v("addi",   32'h00500093, 32'h00000005, 11'b1 << 1,  14'b1 << 0,  4'h0),
         v("sub",    32'h40208133, 32'h00000000, 11'b1 << 0,  14'b1 << 1,  4'h0),
         v("beq",    32'hFE208EE3, 32'hFFFFFFFC, 11'b1 << 4,  14'b1 << 10, 4'h0),
         v("lui",    32'h123452B7, 32'h12345000, 11'b1 << 7,  14'b1 << 0,  4'h0),
         v("jal",    32'h008000EF, 32'h00000008, 11'b1 << 5,  14'b1 << 0,  4'h0),
         v("sw",     32'h0020A223, 32'h00000004, 11'b1 << 3,  14'b1 << 0,  4'h0),
         v("lw",     32'hFF812183, 32'hFFFFFFF8, 11'b1 << 2,  14'b1 << 0,  4'h0),
         v("srai",   32'h4030D213, 32'h00000403, 11'b1 << 1,  14'b1 << 9,  4'h0),
         v("blt",    32'h0020C463, 32'h00000008, 11'b1 << 4,  14'b1 << 2,  4'h0),
         v("bgeu",   32'h0020F463, 32'h00000008, 11'b1 << 4,  14'b1 << 13, 4'h0),
         v("sltu",   32'h0020B333, 32'h00000000, 11'b1 << 0,  14'b1 << 3,  4'h0),
         v("auipc",  32'h00001397, 32'h00001000, 11'b1 << 8,  14'b1 << 0,  4'h0),
         v("jalr",   32'h000100E7, 32'h00000000, 11'b1 << 6,  14'b1 << 0,  4'h0),
         v("allones",32'hFFFFFFFF, 32'h00000000, 11'b0,       14'b0,       4'h1, 1'b0),
         v("badslli",32'h40101093, 32'h00000000, 11'b0,       14'b0,       4'h1, 1'b0),
         v("rvc",    32'h00000001, 32'h00000000, 11'b0,       14'b0,       4'h1, 1'b0),
         v("ecall",  32'h00000073, 32'h00000000, 11'b1 << 9,  14'b0,       4'h2, 1'b1, 1'b0),
         v("ebreak", 32'h00100073, 32'h00000001, 11'b1 << 9,  14'b0,       4'h4, 1'b1, 1'b0),
         v("mret",   32'h30200073, 32'h00000302, 11'b1 << 9,  14'b0,       4'h8, 1'b1, 1'b0),
         v("fence",  32'h0FF0000F, 32'h00000000, 11'b1 << 10, 14'b0,       4'h0, 1'b0, 1'b0)
      };
      addi_v = tbl[0];
      sub_v = tbl[1];
      repeat (2) @(posedge clk);
      #1;
      compare_out(zero_exp("reset"));
      rst = 1'b0;
      foreach (tbl[i]) drive(tbl[i], 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(v("wr_x3",  32'h00300193, 32'h3, 11'b1 << 1, 14'b1, 4'h0), 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
      drive(v("rd_x3",  32'h00018233, 32'h0, 11'b1 << 0, 14'b1, 4'h0), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(v("byp_x5", 32'h00028293, 32'h0, 11'b1 << 1, 14'b1, 4'h0), 1'b1, 1'b0, 1'b0, 1'b1, 32'h12345678);
      drive(v("rd2_x5", 32'h00500333, 32'h0, 11'b1 << 0, 14'b1, 4'h0), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(v("wr_x0",  32'h00000013, 32'h0, 11'b1 << 1, 14'b1, 4'h0), 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
      drive(v("rd_x0",  32'h00000233, 32'h0, 11'b1 << 0, 14'b1, 4'h0), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(sub_v, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(addi_v, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(v("stall", sub_v.instr, sub_v.imm, sub_v.opc, sub_v.alu, 4'h0), 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      drive(v("stall_nce", sub_v.instr, sub_v.imm, sub_v.opc, sub_v.alu, 4'h0), 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      drive(v("flush", addi_v.instr, addi_v.imm, addi_v.opc, addi_v.alu, 4'h0), 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      drive(addi_v, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(v("flush_stall", sub_v.instr, sub_v.imm, sub_v.opc, sub_v.alu, 4'h0), 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      ds_i_instr = 32'h00018233; ds_i_ce = 1'b1; ds_i_stall = 1'b0; ds_i_flush = 1'b0; ds_we = 1'b0;
      #2 rst = 1'b1;
      #1 compare_out(zero_exp("midrst"));
      @(posedge clk);
      #1 compare_out(zero_exp("midrst_edge"));
      rst = 1'b0;
      for (int i = 0; i < 32; i++) regs[i] = '0;
      last = zero_exp("reset");
      drive(v("post_rst", 32'h00018233, 32'h0, 11'b1 << 0, 14'b1, 4'h0), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
